// File: rtl/cpu.sv
// cpu: single-cycle 16-bit register CPU with internal instruction memory,
// data memory and a 16-entry register file. Programs and data are placed in
// imem/dmem by hierarchical writes; progress is observed via the debug outputs.
// Optional feature macro: CPU_HALT_EN (opcode 0xF stops the core until reset).

`ifndef OPCODE_NOP
`define OPCODE_NOP   4'h0
`define OPCODE_ADD   4'h1
`define OPCODE_LOAD  4'h2
`define OPCODE_STORE 4'h3
`define OPCODE_CMP   4'h4
`define OPCODE_JUMP  4'h5
`define OPCODE_JZ    4'h6
`define OPCODE_HALT  4'hF
`endif

module cpu #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] pc_out,
  output logic       zf_out,
  output logic       cf_out,
  output logic       halted
);

  // Storage; names are relied on by hierarchical program/data loading.
  logic [15:0] imem [0:IMEM_DEPTH-1];
  logic [15:0] dmem [0:DMEM_DEPTH-1];
  logic [15:0] regs [0:15];

  logic [7:0]  pc_reg;
  logic [7:0]  pc_next;
  logic        zf_reg;
  logic        zf_next;
  logic        cf_reg;
  logic        cf_next;

  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [7:0]  addr8;
  logic [15:0] rs1_val;
  logic [15:0] rs2_val;
  logic [15:0] rd_val;

  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        dmem_we;

`ifdef CPU_HALT_EN
  logic        halted_reg;
  logic        halted_next;
`endif

  // Instruction fetch and operand reads are combinational.
  assign instr   = imem[pc_reg];
  assign opcode  = instr[15:12];
  assign rd      = instr[11:8];
  assign rs1     = instr[7:4];
  assign rs2     = instr[3:0];
  assign addr8   = instr[7:0];
  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];
  assign rd_val  = regs[rd];

  // Decode/execute: compute next PC, flags and write enables for this instruction.
  always_comb begin
    pc_next   = pc_reg + 8'd1;
    zf_next   = zf_reg;
    cf_next   = cf_reg;
    reg_we    = 1'b0;
    reg_wdata = 16'h0000;
    dmem_we   = 1'b0;
`ifdef CPU_HALT_EN
    halted_next = halted_reg;
`endif
    case (opcode)
      `OPCODE_ADD: begin
        reg_we    = 1'b1;
        reg_wdata = rs1_val + rs2_val;
      end
      `OPCODE_LOAD: begin
        reg_we    = 1'b1;
        reg_wdata = dmem[addr8];
      end
      `OPCODE_STORE: begin
        dmem_we = 1'b1;
      end
      `OPCODE_CMP: begin
        zf_next = (rs1_val == rs2_val);
        cf_next = (rs1_val < rs2_val);
      end
      `OPCODE_JUMP: begin
        pc_next = addr8;
      end
      `OPCODE_JZ: begin
        if (zf_reg) begin
          pc_next = addr8;
        end
      end
`ifdef CPU_HALT_EN
      `OPCODE_HALT: begin
        halted_next = 1'b1;
        pc_next     = pc_reg;
      end
`endif
      default: begin
      end
    endcase
`ifdef CPU_HALT_EN
    // A halted core holds every piece of architectural state.
    if (halted_reg) begin
      pc_next     = pc_reg;
      zf_next     = zf_reg;
      cf_next     = cf_reg;
      reg_we      = 1'b0;
      dmem_we     = 1'b0;
      halted_next = 1'b1;
    end
`endif
  end

  // PC and flags: cleared immediately by reset, otherwise advance each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= 8'h00;
      zf_reg <= 1'b0;
      cf_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      zf_reg <= zf_next;
      cf_reg <= cf_next;
    end
  end

`ifdef CPU_HALT_EN
  // Halt latch: set by HALT, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= halted_next;
    end
  end
  assign halted = halted_reg;
`else
  assign halted = 1'b0;
`endif

  // Register file write; every register clears on reset, reads see the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'h0000;
      end
    end else if (reg_we) begin
      regs[rd] <= reg_wdata;
    end
  end

  // Data memory write; contents survive reset, but no write happens while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (dmem_we) begin
      dmem[addr8] <= rd_val;
    end
  end

  assign pc_out = pc_reg;
  assign zf_out = zf_reg;
  assign cf_out = cf_reg;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs for cpu. Stimulus pushes expected observations into
// a queue; a monitor process compares them against the DUT on the falling edge.

module tb_cpu;

  logic       clk;
  logic       reset;
  logic [7:0] pc_out;
  logic       zf_out;
  logic       cf_out;
  logic       halted;

  cpu dut (
    .clk    (clk),
    .reset  (reset),
    .pc_out (pc_out),
    .zf_out (zf_out),
    .cf_out (cf_out),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_PC, K_ZF, K_CF, K_HALT, K_REG, K_DMEM} kind_t;

  typedef struct {
    string       name;
    kind_t       kind;
    int          idx;
    logic [15:0] exp;
  } chk_t;

  chk_t queue_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] observe(kind_t k, int idx);
    case (k)
      K_PC:    return {8'h00, pc_out};
      K_ZF:    return {15'h0, zf_out};
      K_CF:    return {15'h0, cf_out};
      K_HALT:  return {15'h0, halted};
      K_REG:   return dut.regs[idx];
      default: return dut.dmem[idx];
    endcase
  endfunction

  task automatic expect_val(string name, kind_t k, int idx, logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.kind = k;
    c.idx  = idx;
    c.exp  = exp;
    queue_q.push_back(c);
  endtask

  // Monitor: at each falling edge, drain and compare all pending expectations.
  initial begin
    forever begin
      @(negedge clk);
      while (queue_q.size() > 0) begin
        chk_t c;
        logic [15:0] act;
        c = queue_q.pop_front();
        act = observe(c.kind, c.idx);
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h (t=%0t)", c.name, act, c.exp, $time);
        end else begin
          $display("ok   %s = %h", c.name, act);
        end
      end
    end
  end

  // Advance n rising edges, leaving us 1 ns after the last one.
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset and clear the instruction memory ready for a new program.
  task automatic begin_prog();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) dut.imem[i] = 16'h0000;
  endtask

  // Release reset mid-cycle so the next rising edge commits imem[0].
  task automatic release_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dut.imem[i] = 16'h0000;
      dut.dmem[i] = 16'h0000;
    end
    #2;
    // Reset state
    expect_val("rst_pc", K_PC, 0, 16'h0000);
    expect_val("rst_zf", K_ZF, 0, 16'h0000);
    expect_val("rst_cf", K_CF, 0, 16'h0000);
    expect_val("rst_halted", K_HALT, 0, 16'h0000);
    expect_val("rst_r0", K_REG, 0, 16'h0000);
    expect_val("rst_r15", K_REG, 15, 16'h0000);
    release_reset();

    // All-NOP memory: PC counts once per clock
    for (int i = 1; i <= 10; i++) begin
      step(1);
      expect_val($sformatf("nop_pc%0d", i), K_PC, 0, 16'(i));
    end
    for (int r = 0; r < 16; r++) expect_val($sformatf("nop_r%0d", r), K_REG, r, 16'h0000);
    step(1);

    // Arithmetic, load, store, overflow, self-source ADD, store->load
    begin_prog();
    dut.dmem[5] = 16'h0003;
    dut.dmem[6] = 16'h0004;
    dut.dmem[7] = 16'h0000;
    dut.dmem[8] = 16'hFFFF;
    dut.dmem[9] = 16'h0002;
    dut.imem[0] = 16'h2105; // LOAD r1,[5]
    dut.imem[1] = 16'h2206; // LOAD r2,[6]
    dut.imem[2] = 16'h1312; // ADD r3,r1,r2
    dut.imem[3] = 16'h3307; // STORE r3,[7]
    dut.imem[4] = 16'h2408; // LOAD r4,[8]
    dut.imem[5] = 16'h2509; // LOAD r5,[9]
    dut.imem[6] = 16'h1645; // ADD r6,r4,r5
    dut.imem[7] = 16'h1111; // ADD r1,r1,r1
    dut.imem[8] = 16'h2A07; // LOAD r10,[7]
    release_reset();
    step(1); expect_val("ld_r1", K_REG, 1, 16'h0003);
    step(1); expect_val("ld_r2", K_REG, 2, 16'h0004);
    step(1); expect_val("add_r3", K_REG, 3, 16'h0007);
    step(1); expect_val("st_dmem7", K_DMEM, 7, 16'h0007);
             expect_val("st_pc", K_PC, 0, 16'h0004);
    step(2); expect_val("ld_r4", K_REG, 4, 16'hFFFF);
    step(1); expect_val("ovf_r6", K_REG, 6, 16'h0001);
             expect_val("ovf_zf", K_ZF, 0, 16'h0000);
    step(1); expect_val("dbl_r1", K_REG, 1, 16'h0006);
    step(1); expect_val("stld_r10", K_REG, 10, 16'h0007);

    // CMP equal + JZ taken; CMP 3 vs 4 + JZ not taken; CMP 4 vs 3
    step(1);
    begin_prog();
    dut.imem[0]     = 16'h2105; // LOAD r1,[5] = 3
    dut.imem[1]     = 16'h2205; // LOAD r2,[5] = 3
    dut.imem[2]     = 16'h4012; // CMP r1,r2
    dut.imem[3]     = 16'h6010; // JZ 0x10
    dut.imem[8'h10] = 16'h2206; // LOAD r2,[6] = 4
    dut.imem[8'h11] = 16'h4012; // CMP r1,r2
    dut.imem[8'h12] = 16'h6030; // JZ 0x30
    dut.imem[8'h13] = 16'h4021; // CMP r2,r1
    release_reset();
    step(3); expect_val("cmpeq_zf", K_ZF, 0, 16'h0001);
             expect_val("cmpeq_cf", K_CF, 0, 16'h0000);
    step(1); expect_val("jz_taken_pc", K_PC, 0, 16'h0010);
    step(2); expect_val("cmplt_zf", K_ZF, 0, 16'h0000);
             expect_val("cmplt_cf", K_CF, 0, 16'h0001);
    step(1); expect_val("jz_fall_pc", K_PC, 0, 16'h0013);
    step(1); expect_val("cmpgt_cf", K_CF, 0, 16'h0000);

    // JUMP loop 0,1,2,0,1,2
    step(1);
    begin_prog();
    dut.imem[2] = 16'h5000;
    release_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1);
      expect_val($sformatf("loop_pc%0d", i), K_PC, 0, 16'(i % 3));
    end

    // PC wrap 0xFE, 0xFF, 0x00
    step(1);
    begin_prog();
    dut.imem[0] = 16'h50FE;
    release_reset();
    step(1); expect_val("wrap_fe", K_PC, 0, 16'h00FE);
    step(1); expect_val("wrap_ff", K_PC, 0, 16'h00FF);
    step(1); expect_val("wrap_00", K_PC, 0, 16'h0000);

    // Asynchronous reset while ADD is the current instruction
    step(1);
    begin_prog();
    dut.dmem[8'h20] = 16'h0000;
    dut.imem[0] = 16'h2105; // LOAD r1,[5] = 3
    dut.imem[1] = 16'h2205; // LOAD r2,[5] = 3
    dut.imem[2] = 16'h4012; // CMP -> zf=1
    dut.imem[3] = 16'h3120; // STORE r1,[0x20]
    dut.imem[4] = 16'h1312; // ADD r3,r1,r2
    release_reset();
    step(3); expect_val("ar_pre_zf", K_ZF, 0, 16'h0001);
    step(1); // now at posedge+1, PC=4 (ADD pending)
    #1;
    reset = 1'b1;
    #1;
    expect_val("ar_pc", K_PC, 0, 16'h0000);
    expect_val("ar_zf", K_ZF, 0, 16'h0000);
    expect_val("ar_r1", K_REG, 1, 16'h0000);
    expect_val("ar_r3", K_REG, 3, 16'h0000);
    expect_val("ar_dmem", K_DMEM, 8'h20, 16'h0003);
    step(1); expect_val("ar_hold_r3", K_REG, 3, 16'h0000);

    // HALT at imem[3]
    step(1);
    begin_prog();
    dut.imem[3] = 16'hF000;
    release_reset();
    step(4);
`ifdef CPU_HALT_EN
    expect_val("halt_flag", K_HALT, 0, 16'h0001);
    expect_val("halt_pc", K_PC, 0, 16'h0003);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      expect_val($sformatf("halt_pc_hold%0d", i), K_PC, 0, 16'h0003);
    end
    expect_val("halt_flag_end", K_HALT, 0, 16'h0001);
`else
    expect_val("nohalt_flag", K_HALT, 0, 16'h0000);
    expect_val("nohalt_pc", K_PC, 0, 16'h0004);
    step(1);
    expect_val("nohalt_pc5", K_PC, 0, 16'h0005);
`endif

    // Let the monitor drain, bounded.
    for (int w = 0; w < 20 && queue_q.size() > 0; w++) @(posedge clk);
    if (queue_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", queue_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu.md
# cpu

Single-cycle 16-bit accumulator-free register CPU with internal instruction memory, data memory and register file. It is the top-level compute core of the design. It has only clock and reset as functional inputs. Program and data are loaded by hierarchical writes to its internal arrays, and execution is observed through debug outputs.

## Interface
- `IMEM_DEPTH`, default 256: instruction words; the PC is 8 bits.
- `DMEM_DEPTH`, default 256: 16-bit data words.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears PC, registers and flags.
- `pc_out` out 8: current PC.
- `zf_out` out 1: zero/equal flag.
- `cf_out` out 1: unsigned-less-than flag.
- `halted` out 1: core stopped.
- Internal arrays, names fixed for bench access:
  - `imem[0:255]` 16-bit.
  - `dmem[0:255]` 16-bit.
  - `regs[0:15]` 16-bit.

## Operation
- Opcode values come from `OPCODE_*` macros in `instruction.vh`.
- Instruction format:
  - `[15:12]` opcode
  - `[11:8]` rd/rs
  - `[7:4]` rs1
  - `[3:0]` rs2
  - `[7:0]` addr8/target8 for memory and jumps
- Opcodes:
  - `OPCODE_NOP`=0x0: no effect; PC+1.
  - `OPCODE_ADD`=0x1: `regs[rd] = regs[rs1] + regs[rs2]` mod 2^16. Flags unchanged.
  - `OPCODE_LOAD`=0x2: `regs[rd] = dmem[addr8]`.
  - `OPCODE_STORE`=0x3: `dmem[addr8] = regs[rs]`, where rs is field `[11:8]`.
  - `OPCODE_CMP`=0x4: `zf = (regs[rs1]==regs[rs2])`; `cf = (regs[rs1]<regs[rs2])` unsigned. No register write.
  - `OPCODE_JUMP`=0x5: `PC = target8`.
  - `OPCODE_JZ`=0x6: `PC = target8` if `zf==1`, else PC+1.
  - `OPCODE_HALT`=0xF: see Configuration.
  - All other opcodes execute as NOP.
- All 16 registers are general purpose; r0 is not hardwired.
- Register reads are combinational.
- Same-register source and destination reads the old value (e.g. ADD r1,r1,r1 doubles r1).
- `imem` and `dmem` are not cleared by reset; contents survive reset.
- `regs` are all cleared to 0 by reset.

## Timing
- Reset state: `pc_out`=0, `zf_out`=0, `cf_out`=0, `halted`=0, all `regs`=0.
- Reset is asynchronous. Asserting it mid-program aborts immediately; the instruction in progress is not committed.
- The first instruction, `imem[0]`, commits on the first rising edge after reset deasserts.
- One instruction commits per rising edge. Register, memory, flag and PC updates are all visible after that edge.
- PC increments mod 256; 255 wraps to 0.
- LOAD is a combinational dmem read and writes its register at the same edge.
- STORE followed by LOAD of the same address returns the new value.

## Configuration
- `CPU_HALT_EN` defined:
  - `OPCODE_HALT` sets `halted`=1 and freezes PC at the HALT address.
  - No further state changes occur until reset.
  - `halted` stays 1 until reset.
- `CPU_HALT_EN` undefined:
  - 0xF executes as NOP.
  - `halted` is tied to 0.

## Test plan
- Reset held 10 ns, then released with `imem` all zeros → `pc_out` counts 0,1,2… once per 10 ns clock. After 100 ns, `pc_out`=10 and all `regs`=0.
- Arithmetic, load and store:
  - Setup: `dmem[5]`=0x0003, `dmem[6]`=0x0004.
  - Program: LOAD r1,[5]; LOAD r2,[6]; ADD r3,r1,r2; STORE r3,[7].
  - Required: `dmem[7]`=0x0007 after 4 cycles.
  - Overflow: 0xFFFF+0x0002 gives 0x0001.
- CMP equal, then JZ to 0x10 → `zf_out`=1 and PC=0x10. CMP 3 vs 4 → `zf`=0, `cf`=1, and a following JZ falls through.
- Program JUMP 0x00 at `imem[2]` → PC sequence 0,1,2,0,1,2… Separately, with PC running through 255 → next PC is 0.
- Assert reset asynchronously mid-ADD, between clock edges → PC, regs and flags become 0 at once; the ADD result is not written; `dmem` is retained.
- With `CPU_HALT_EN`, HALT at `imem[3]` → `halted`=1 and `pc_out` stays 3 for 10 cycles. Without the macro → PC reaches 4.
